// File: rtl/mc_ctrl_if.sv
// Control bus between the multicycle controller and the datapath: instruction
// fields and status flags in, datapath strobes and selects out.
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       zero;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_we;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] npc_sel;
  logic       reg_we;
  logic [1:0] reg_dst;
  logic [1:0] wd_sel;
  logic [1:0] alu_op;
  logic       ext_op;
  logic       retire;
  logic       illegal;

  modport master (
    input  op, func, zero, mem_ack,
    output mem_req, mem_we, ir_we, pc_we, npc_sel, reg_we, reg_dst,
           wd_sel, alu_op, ext_op, retire, illegal
  );

  modport slave (
    output op, func, zero, mem_ack,
    input  mem_req, mem_we, ir_we, pc_we, npc_sel, reg_we, reg_dst,
           wd_sel, alu_op, ext_op, retire, illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB state machine
// with Mealy-style strobes derived from state, opcode, zero and mem_ack.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  mc_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_ILL
  } instr_t;

  state_t state, state_next;
  instr_t instr;

  // Classify the held instruction once so the FSM logic only sees classes.
  always_comb begin
    instr = I_ILL;
    case (bus.op)
      6'b000000: begin
        case (bus.func)
          6'b100001: instr = I_ADDU;
          6'b100011: instr = I_SUBU;
          6'b001000: instr = I_JR;
          default:   instr = I_ILL;
        endcase
      end
      6'b001101: instr = I_ORI;
      6'b001111: instr = I_LUI;
      6'b100011: instr = I_LW;
      6'b101011: instr = I_SW;
      6'b000100: instr = I_BEQ;
      6'b000010: instr = I_J;
      6'b000011: instr = I_JAL;
      default:   instr = I_ILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = bus.mem_ack ? DECODE : FETCH;
      DECODE: begin
        case (instr)
          I_J, I_JAL, I_JR, I_ILL: state_next = FETCH;
          default:                 state_next = EXEC;
        endcase
      end
      EXEC: begin
        case (instr)
          I_BEQ:      state_next = FETCH;
          I_LW, I_SW: state_next = MEM;
          default:    state_next = WB;
        endcase
      end
      MEM: begin
        if (!bus.mem_ack)       state_next = MEM;
        else if (instr == I_SW) state_next = FETCH;
        else                    state_next = WB;
      end
      WB:      state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Reset forces every strobe low so an abandoned instruction never commits.
  always_comb begin
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    bus.ir_we   = 1'b0;
    bus.pc_we   = 1'b0;
    bus.npc_sel = 2'd0;
    bus.reg_we  = 1'b0;
    bus.reg_dst = 2'd0;
    bus.wd_sel  = 2'd0;
    bus.alu_op  = 2'd0;
    bus.ext_op  = 1'b0;
    bus.retire  = 1'b0;
    bus.illegal = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          bus.mem_req = 1'b1;
          bus.ir_we   = bus.mem_ack;
        end
        DECODE: begin
          case (instr)
            I_J: begin
              bus.pc_we   = 1'b1;
              bus.npc_sel = 2'd2;
              bus.retire  = 1'b1;
            end
            I_JAL: begin
              bus.pc_we   = 1'b1;
              bus.npc_sel = 2'd2;
              bus.retire  = 1'b1;
              bus.reg_we  = 1'b1;
              bus.reg_dst = 2'd2;
              bus.wd_sel  = 2'd2;
            end
            I_JR: begin
              bus.pc_we   = 1'b1;
              bus.npc_sel = 2'd3;
              bus.retire  = 1'b1;
            end
            I_ILL: begin
              bus.illegal = 1'b1;
              bus.pc_we   = 1'b1;
              bus.retire  = 1'b1;
            end
            default: ;
          endcase
        end
        EXEC: begin
          case (instr)
            I_SUBU, I_BEQ: bus.alu_op = 2'd1;
            I_ORI:         bus.alu_op = 2'd2;
            I_LUI:         bus.alu_op = 2'd3;
            default:       bus.alu_op = 2'd0;
          endcase
          bus.ext_op = (instr == I_LW) || (instr == I_SW) || (instr == I_BEQ);
          if (instr == I_BEQ) begin
            bus.pc_we   = 1'b1;
            bus.retire  = 1'b1;
            bus.npc_sel = bus.zero ? 2'd1 : 2'd0;
          end
        end
        MEM: begin
          bus.mem_req = 1'b1;
          bus.mem_we  = (instr == I_SW);
          bus.ext_op  = 1'b1;
          if (bus.mem_ack && instr == I_SW) begin
            bus.pc_we  = 1'b1;
            bus.retire = 1'b1;
          end
        end
        WB: begin
          bus.reg_we = 1'b1;
          bus.pc_we  = 1'b1;
          bus.retire = 1'b1;
          case (instr)
            I_LW:   bus.wd_sel  = 2'd1;
            I_ADDU: bus.reg_dst = 2'd1;
            I_SUBU: begin
              bus.reg_dst = 2'd1;
              bus.alu_op  = 2'd1;
            end
            I_ORI:  bus.alu_op = 2'd2;
            I_LUI:  bus.alu_op = 2'd3;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed cycle-by-cycle bench for mc_ctrl: a table of per-cycle inputs and
// hand-derived output words, plus stall and reset-in-MEM sequences.
module tb_mc_ctrl;

  // Output word layout: mem_req mem_we ir_we pc_we npc_sel reg_we reg_dst wd_sel alu_op ext_op retire illegal
  localparam logic [15:0] MREQ = 16'h8000, MWE  = 16'h4000, IRWE = 16'h2000;
  localparam logic [15:0] PCWE = 16'h1000, NPC1 = 16'h0400, NPC2 = 16'h0800;
  localparam logic [15:0] NPC3 = 16'h0C00, RWE  = 16'h0200, DST1 = 16'h0080;
  localparam logic [15:0] DST2 = 16'h0100, WD1  = 16'h0020, WD2  = 16'h0040;
  localparam logic [15:0] ALU1 = 16'h0008, ALU2 = 16'h0010, ALU3 = 16'h0018;
  localparam logic [15:0] EXT  = 16'h0004, RET  = 16'h0002, ILL  = 16'h0001;
  localparam logic [15:0] NONE = 16'h0000;

  localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_JR = 6'b001000;
  localparam logic [5:0] F_NONE = 6'b000000;

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        zero;
    logic        ack;
    logic [15:0] expected;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[$];

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] observed();
    return {bus.mem_req, bus.mem_we, bus.ir_we, bus.pc_we, bus.npc_sel,
            bus.reg_we, bus.reg_dst, bus.wd_sel, bus.alu_op, bus.ext_op,
            bus.retire, bus.illegal};
  endfunction

  task automatic add_vec(input string name, input logic rst, input logic [5:0] op,
                         input logic [5:0] func, input logic zero, input logic ack,
                         input logic [15:0] expected);
    vec_t v;
    v.name = name; v.rst = rst; v.op = op; v.func = func;
    v.zero = zero; v.ack = ack; v.expected = expected;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input logic rst, input logic [5:0] op,
                                input logic [5:0] func, input logic zero,
                                input logic ack);
    reset       = rst;
    bus.op      = op;
    bus.func    = func;
    bus.zero    = zero;
    bus.mem_ack = ack;
  endtask

  // Outputs are sampled on the falling edge, then the bench moves past the next rising edge.
  task automatic check_output(input string name, input logic [15:0] expected);
    logic [15:0] got;
    @(negedge clk);
    got = observed();
    checks++;
    if (got !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, want %b", name, got, expected);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input string name, input logic rst, input logic [5:0] op,
                       input logic [5:0] func, input logic zero, input logic ack,
                       input logic [15:0] expected);
    apply_stimulus(rst, op, func, zero, ack);
    check_output(name, expected);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    add_vec("reset_0",     1, OP_ORI, F_NONE, 0, 1, NONE);
    add_vec("reset_1",     1, OP_ORI, F_NONE, 0, 1, NONE);
    add_vec("ori_fetch",   0, OP_ORI, F_NONE, 0, 1, MREQ | IRWE);
    add_vec("ori_decode",  0, OP_ORI, F_NONE, 0, 1, NONE);
    add_vec("ori_exec",    0, OP_ORI, F_NONE, 0, 1, ALU2);
    add_vec("ori_wb",      0, OP_ORI, F_NONE, 0, 1, RWE | PCWE | RET | ALU2);
    add_vec("fetch_stall", 0, OP_JAL, F_NONE, 0, 0, MREQ);
    add_vec("jal_fetch",   0, OP_JAL, F_NONE, 0, 1, MREQ | IRWE);
    add_vec("jal_decode",  0, OP_JAL, F_NONE, 0, 1, PCWE | NPC2 | RET | RWE | DST2 | WD2);
    add_vec("j_fetch",     0, OP_J,   F_NONE, 0, 1, MREQ | IRWE);
    add_vec("j_decode",    0, OP_J,   F_NONE, 0, 1, PCWE | NPC2 | RET);
    add_vec("jr_fetch",    0, OP_R,   F_JR,   0, 1, MREQ | IRWE);
    add_vec("jr_decode",   0, OP_R,   F_JR,   0, 1, PCWE | NPC3 | RET);
    add_vec("ill_fetch",   0, OP_R,   F_NONE, 0, 1, MREQ | IRWE);
    add_vec("ill_decode",  0, OP_R,   F_NONE, 0, 1, ILL | PCWE | RET);
    add_vec("beqt_fetch",  0, OP_BEQ, F_NONE, 1, 1, MREQ | IRWE);
    add_vec("beqt_decode", 0, OP_BEQ, F_NONE, 1, 1, NONE);
    add_vec("beqt_exec",   0, OP_BEQ, F_NONE, 1, 1, ALU1 | EXT | PCWE | NPC1 | RET);
    add_vec("beqn_fetch",  0, OP_BEQ, F_NONE, 0, 1, MREQ | IRWE);
    add_vec("beqn_decode", 0, OP_BEQ, F_NONE, 0, 1, NONE);
    add_vec("beqn_exec",   0, OP_BEQ, F_NONE, 0, 1, ALU1 | EXT | PCWE | RET);
    add_vec("addu_fetch",  0, OP_R,   F_ADDU, 0, 1, MREQ | IRWE);
    add_vec("addu_decode", 0, OP_R,   F_ADDU, 0, 1, NONE);
    add_vec("addu_exec",   0, OP_R,   F_ADDU, 0, 1, NONE);
    add_vec("addu_wb",     0, OP_R,   F_ADDU, 0, 1, RWE | PCWE | RET | DST1);
    add_vec("subu_fetch",  0, OP_R,   F_SUBU, 0, 1, MREQ | IRWE);
    add_vec("subu_decode", 0, OP_R,   F_SUBU, 0, 1, NONE);
    add_vec("subu_exec",   0, OP_R,   F_SUBU, 0, 1, ALU1);
    add_vec("subu_wb",     0, OP_R,   F_SUBU, 0, 1, RWE | PCWE | RET | DST1 | ALU1);
    add_vec("lui_fetch",   0, OP_LUI, F_NONE, 0, 1, MREQ | IRWE);
    add_vec("lui_decode",  0, OP_LUI, F_NONE, 0, 1, NONE);
    add_vec("lui_exec",    0, OP_LUI, F_NONE, 0, 1, ALU3);
    add_vec("lui_wb",      0, OP_LUI, F_NONE, 0, 1, RWE | PCWE | RET | ALU3);
    add_vec("sw_fetch",    0, OP_SW,  F_NONE, 0, 1, MREQ | IRWE);
    add_vec("sw_decode",   0, OP_SW,  F_NONE, 0, 1, NONE);
    add_vec("sw_exec",     0, OP_SW,  F_NONE, 0, 1, EXT);
    add_vec("sw_mem",      0, OP_SW,  F_NONE, 0, 1, MREQ | MWE | EXT | PCWE | RET);
    add_vec("badop_fetch", 0, OP_BAD, F_NONE, 0, 1, MREQ | IRWE);
    add_vec("badop_dec",   0, OP_BAD, F_NONE, 0, 1, ILL | PCWE | RET);

    #1;
    foreach (vecs[i])
      cycle(vecs[i].name, vecs[i].rst, vecs[i].op, vecs[i].func,
            vecs[i].zero, vecs[i].ack, vecs[i].expected);

    // lw with three stalled MEM cycles: eight cycles from fetch to retire.
    cycle("lw_fetch",  0, OP_LW, F_NONE, 0, 1, MREQ | IRWE);
    cycle("lw_decode", 0, OP_LW, F_NONE, 0, 1, NONE);
    cycle("lw_exec",   0, OP_LW, F_NONE, 0, 1, EXT);
    for (int k = 0; k < 3; k++)
      cycle($sformatf("lw_mem_stall%0d", k), 0, OP_LW, F_NONE, 0, 0, MREQ | EXT);
    cycle("lw_mem_ack", 0, OP_LW, F_NONE, 0, 1, MREQ | EXT);
    cycle("lw_wb",      0, OP_LW, F_NONE, 0, 1, RWE | PCWE | RET | WD1);

    // sw abandoned by a one-cycle reset while waiting in MEM.
    cycle("swr_fetch",  0, OP_SW, F_NONE, 0, 1, MREQ | IRWE);
    cycle("swr_decode", 0, OP_SW, F_NONE, 0, 1, NONE);
    cycle("swr_exec",   0, OP_SW, F_NONE, 0, 1, EXT);
    cycle("swr_mem",    0, OP_SW, F_NONE, 0, 0, MREQ | MWE | EXT);
    cycle("swr_reset",  1, OP_SW, F_NONE, 0, 1, NONE);
    cycle("swr_refetch", 0, OP_SW, F_NONE, 0, 0, MREQ);
    cycle("swr_fetch2", 0, OP_J,  F_NONE, 0, 1, MREQ | IRWE);
    cycle("swr_j_dec",  0, OP_J,  F_NONE, 0, 1, PCWE | NPC2 | RET);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
